// File: rtl/boxcar_sched_pkg.sv
// Shared types and constants for the boxcar baseline scheduler.
// Build option: BOXCAR_SCHED_ROUND_EN selects the rounded/saturated mean in the top.
package boxcar_sched_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Accumulator width that cannot overflow for a full window of samples.
    function automatic int unsigned acc_width(input int unsigned log2_win);
        return SAMPLE_W + log2_win;
    endfunction

    function automatic int unsigned sched_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr, wrapping.
module rr_arbiter
    import boxcar_sched_pkg::*;
#(
    parameter int unsigned NCH = 4,
    localparam int unsigned IDX_W = sched_clog2(NCH)
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NCH-1:0]   gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NCH);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/boxcar_baseline_sched.sv
// Time-shared boxcar averager: round-robin grant, settle discard, 2^LOG2_WIN-sample mean.
// Build option: BOXCAR_SCHED_ROUND_EN enables round-half-up with positive saturation.
module boxcar_baseline_sched
    import boxcar_sched_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned LOG2_WIN = 10,
    parameter int unsigned SETTLE   = 8,
    localparam int unsigned IDX_W   = sched_clog2(NCH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCH*SAMPLE_W-1:0]   x_bus,
    input  logic                      x_valid,
    input  logic [NCH-1:0]            req,
    output logic [NCH-1:0]            grant,
    output logic                      busy,
    output logic                      done,
    output logic [SAMPLE_W-1:0]       y,
    output logic [IDX_W-1:0]          y_ch
);

    localparam int unsigned ACC_W = acc_width(LOG2_WIN);
    localparam int unsigned CNT_W = (LOG2_WIN > 8) ? LOG2_WIN : 8;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'((32'd1 << LOG2_WIN) - 1);

    state_t                    state, state_nxt;
    logic [NCH-1:0]            grant_nxt;
    logic                      busy_nxt, done_nxt;
    logic [SAMPLE_W-1:0]       y_nxt;
    logic [IDX_W-1:0]          y_ch_nxt;
    logic [IDX_W-1:0]          ptr, ptr_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic signed [ACC_W-1:0]   acc, acc_nxt, sum;
    logic signed [SAMPLE_W-1:0] lane [NCH];
    logic signed [SAMPLE_W-1:0] x_sel;
    logic signed [SAMPLE_W-1:0] mean;
    logic [NCH-1:0]            arb_gnt;
    logic [IDX_W-1:0]          arb_idx;
    logic [IDX_W-1:0]          idx_after;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Input mux for the currently granted channel.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            lane[i] = x_bus[i*SAMPLE_W +: SAMPLE_W];
        end
        x_sel = lane[idx];
    end

    assign sum       = acc + ACC_W'(x_sel);
    assign idx_after = (idx == IDX_W'(NCH - 1)) ? '0 : idx + IDX_W'(1);

`ifdef BOXCAR_SCHED_ROUND_EN
    localparam logic signed [ACC_W:0] ROUND_HALF = (ACC_W+1)'(32'd1 << (LOG2_WIN - 1));
    localparam logic signed [ACC_W:0] SAT_MAX    = (ACC_W+1)'(32'd32767);
    logic signed [ACC_W:0] rnd, shr;

    always_comb begin
        rnd  = (ACC_W+1)'(sum) + ROUND_HALF;
        shr  = rnd >>> LOG2_WIN;
        mean = (shr > SAT_MAX) ? 16'sh7FFF : SAMPLE_W'(shr);
    end
`else
    always_comb begin
        mean = SAMPLE_W'(sum >>> LOG2_WIN);
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        done_nxt  = 1'b0;
        y_nxt     = y;
        y_ch_nxt  = y_ch;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        acc_nxt   = acc;

        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_nxt = arb_gnt;
                    idx_nxt   = arb_idx;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!req[idx]) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = idx_after;
                end else if (x_valid) begin
                    if (cnt == SETTLE_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_ACCUM;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_ACCUM: begin
                if (!req[idx]) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = idx_after;
                end else if (x_valid) begin
                    acc_nxt = sum;
                    if (cnt == WIN_LAST) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        y_nxt     = mean;
                        y_ch_nxt  = idx;
                        grant_nxt = '0;
                        ptr_nxt   = idx_after;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_ACCUM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
            y_ch  <= '0;
            ptr   <= '0;
            idx   <= '0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            y     <= y_nxt;
            y_ch  <= y_ch_nxt;
            ptr   <= ptr_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_boxcar_baseline_sched.sv
// Directed bench for boxcar_baseline_sched with NCH=4, LOG2_WIN=4, SETTLE=2.
module tb_boxcar_baseline_sched;

    logic        clk;
    logic        reset;
    logic [63:0] x_bus;
    logic        x_valid;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic [15:0] y;
    logic [1:0]  y_ch;

    int n_tests = 0;
    int n_fail  = 0;

    boxcar_baseline_sched #(.NCH(4), .LOG2_WIN(4), .SETTLE(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .x_bus   (x_bus),
        .x_valid (x_valid),
        .req     (req),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .y       (y),
        .y_ch    (y_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        x_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_lane(input int ch, input logic [15:0] v);
        x_bus[ch*16 +: 16] = v;
    endtask

    // Bounded wait for a grant to appear; gap counts edges waited.
    task automatic wait_grant(output int gap);
        gap = 0;
        while (grant == '0 && gap < 50) begin
            @(negedge clk);
            gap++;
        end
    endtask

    // Drive x_valid with the given duty until done, counting strobes consumed while granted.
    task automatic wait_done(input string tag, input int duty, input bit alt,
                             output int cycles, output int strobes);
        bit tog;
        tog     = 1'b0;
        cycles  = 0;
        strobes = 0;
        while (!done && cycles < 400) begin
            x_valid = ((cycles % duty) == 0);
            if (alt) begin
                set_lane(0, tog ? 16'hFFFC : 16'hFFFD);
                tog = !tog;
            end
            if (x_valid && grant != '0) strobes++;
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    int          gap, cyc, stb;
    logic [15:0] ey;
    int          vals [4];

    initial begin
        x_bus   = '0;
        vals    = '{-1000, 7, 300, -32768};

        // Reset state
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_y",     32'(y),     32'd0);
        check("rst_ych",   32'(y_ch),  32'd0);

        // 1: ch1 constant +100
        set_lane(1, 16'd100);
        x_valid = 1'b1;
        req     = 4'b0010;
        wait_grant(gap);
        check("t1_gap",   32'(gap),   32'd1);
        check("t1_grant", 32'(grant), 32'b0010);
        check("t1_busy",  32'(busy),  32'd1);
        wait_done("t1", 1, 1'b0, cyc, stb);
        check("t1_lat",    32'(cyc),   32'd18);
        check("t1_y",      32'(y),     32'd100);
        check("t1_ych",    32'(y_ch),  32'd1);
        check("t1_gnt_dn", 32'(grant), 32'd0);
        check("t1_busy_dn",32'(busy),  32'd0);
        req = '0;
        @(negedge clk);
        check("t1_pulse",  32'(done), 32'd0);
        check("t1_hold",   32'(y),    32'd100);

        // 2: ch0 alternating -3/-4, sum -56
        req = 4'b0001;
        wait_grant(gap);
        check("t2_grant", 32'(grant), 32'b0001);
        wait_done("t2", 1, 1'b1, cyc, stb);
`ifdef BOXCAR_SCHED_ROUND_EN
        ey = 16'hFFFD;
`else
        ey = 16'hFFFC;
`endif
        check("t2_y",   32'(y),    32'(ey));
        check("t2_ych", 32'(y_ch), 32'd0);
        req = '0;

        // 3: all requesting, strict round-robin
        do_reset();
        for (int c = 0; c < 4; c++) set_lane(c, 16'(vals[c]));
        x_valid = 1'b1;
        req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(gap);
            check($sformatf("t3_gap%0d", k),   32'(gap),   (k == 0) ? 32'd1 : 32'd2);
            check($sformatf("t3_grant%0d", k), 32'(grant), 32'd1 << (k % 4));
            wait_done($sformatf("t3_w%0d", k), 1, 1'b0, cyc, stb);
            ey = 16'(vals[k % 4]);
            check($sformatf("t3_ych%0d", k), 32'(y_ch), 32'(k % 4));
            check($sformatf("t3_y%0d", k),   32'(y),    32'(ey));
        end

        // 4: abandon ch2 mid-accumulation, ptr moves past it
        req = 4'b0100;
        wait_grant(gap);
        check("t4_grant", 32'(grant), 32'b0100);
        x_valid = 1'b1;
        repeat (7) @(negedge clk);
        check("t4_busy_mid", 32'(busy), 32'd1);
        req = 4'b1011;
        @(negedge clk);
        check("t4_grant0", 32'(grant), 32'd0);
        check("t4_busy0",  32'(busy),  32'd0);
        check("t4_nodone", 32'(done),  32'd0);
        check("t4_yhold",  32'(y),     32'hFC18);
        wait_grant(gap);
        check("t4_gap",    32'(gap),   32'd1);
        check("t4_next",   32'(grant), 32'b1000);
        req = 4'b1000;
        wait_done("t4", 1, 1'b0, cyc, stb);
        check("t4_y",   32'(y),    32'h8000);
        check("t4_ych", 32'(y_ch), 32'd3);

        // 5: reset mid-accumulation
        req = 4'b0100;
        wait_grant(gap);
        check("t5_grant_a", 32'(grant), 32'b0100);
        wait_done("t5a", 1, 1'b0, cyc, stb);
        check("t5_ya", 32'(y), 32'd300);
        req = 4'b0010;
        wait_grant(gap);
        check("t5_grant_b", 32'(grant), 32'b0010);
        repeat (6) @(negedge clk);
        check("t5_busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
        check("t5_grant_r", 32'(grant), 32'd0);
        check("t5_busy_r",  32'(busy),  32'd0);
        check("t5_done_r",  32'(done),  32'd0);
        check("t5_y_r",     32'(y),     32'd0);
        check("t5_ych_r",   32'(y_ch),  32'd0);
        req = 4'b1010;
        @(negedge clk);
        check("t5_restart", 32'(grant), 32'b0010);
        wait_done("t5b", 1, 1'b0, cyc, stb);
        check("t5_yb",   32'(y),    32'd7);
        check("t5_ychb", 32'(y_ch), 32'd1);
        req = '0;

        // 6: sparse x_valid, then full-scale input
        do_reset();
        set_lane(0, 16'd100);
        set_lane(1, 16'h7FFF);
        req = 4'b0001;
        wait_grant(gap);
        check("t6_grant", 32'(grant), 32'b0001);
        wait_done("t6a", 4, 1'b0, cyc, stb);
        check("t6_strobes", 32'(stb), 32'd18);
        check("t6_y",       32'(y),   32'd100);
        req = 4'b0010;
        wait_grant(gap);
        wait_done("t6b", 1, 1'b0, cyc, stb);
        check("t6_strobes_b", 32'(stb),  32'd18);
        check("t6_ysat",      32'(y),    32'h7FFF);
        check("t6_ych",       32'(y_ch), 32'd1);
        req = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
